// File: rtl/frame_fifo_fill_ctrl_if.sv
// frame_fifo_fill_ctrl_if: memory read port and FIFO write port seen by the refill scheduler
interface frame_fifo_fill_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned LEN_WIDTH = 8
);
  logic rd_req_valid;
  logic rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic [LEN_WIDTH-1:0] rd_req_len;
  logic rd_data_valid;
  logic [127:0] rd_data;
  logic rd_data_last;
  logic fifo_wr_en;
  logic [127:0] fifo_wr_data;
  logic fifo_almost_full;
  logic fifo_full;
  modport master (
    output rd_req_valid, rd_req_addr, rd_req_len, fifo_wr_en, fifo_wr_data,
    input  rd_req_ready, rd_data_valid, rd_data, rd_data_last, fifo_almost_full, fifo_full
  );
  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_len, fifo_wr_en, fifo_wr_data,
    output rd_req_ready, rd_data_valid, rd_data, rd_data_last, fifo_almost_full, fifo_full
  );
endinterface

// File: rtl/frame_fifo_fill_ctrl.sv
// frame_fifo_fill_ctrl: walks a frame buffer in read bursts and forwards returned beats into the frame FIFO
module frame_fifo_fill_ctrl #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = 28'h0000000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = 28'h0100000,
  parameter int unsigned FRAME_BEATS = 38400,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned BEAT_BYTES = 16,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic buf_sel,
  frame_fifo_fill_ctrl_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic err_overflow,
  output logic err_last
);
  localparam int unsigned REM_W = $clog2(FRAME_BEATS + 1);
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, DATA} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic restart_q, restart_d;
  logic rsel_q, rsel_d;
  logic wr_en_q, wr_en_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;
  logic lerr_q, lerr_d;
  logic last_beat;
  assign last_beat = cnt_q == len_q - LEN_WIDTH'(1);
  assign bus.rd_req_valid = state_q == REQ;
  assign bus.rd_req_addr = addr_q;
  assign bus.rd_req_len = len_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign busy = state_q != IDLE;
  assign frame_done = done_q;
  assign err_overflow = ovf_q;
  assign err_last = lerr_q;
  // next state: a restart requested while a request or burst is outstanding is applied when that burst ends
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    len_d = len_q;
    cnt_d = cnt_q;
    restart_d = restart_q;
    rsel_d = rsel_q;
    wr_en_d = bus.rd_data_valid && state_q == DATA;
    wr_data_d = wr_en_d ? bus.rd_data : wr_data_q;
    done_d = 1'b0;
    ovf_d = ovf_q || (bus.rd_data_valid && bus.fifo_full);
    lerr_d = lerr_q || (bus.rd_data_valid && (state_q != DATA || bus.rd_data_last != last_beat));
    if (frame_start && (state_q == REQ || state_q == DATA)) begin
      restart_d = 1'b1;
      rsel_d = buf_sel;
    end
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          addr_d = buf_sel ? BASE_ADDR1 : BASE_ADDR0;
          rem_d = REM_W'(FRAME_BEATS);
          state_d = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (frame_start) begin
          addr_d = buf_sel ? BASE_ADDR1 : BASE_ADDR0;
          rem_d = REM_W'(FRAME_BEATS);
        end
        if (!bus.fifo_almost_full) begin
          len_d = 32'(rem_d) > BURST_LEN ? LEN_WIDTH'(BURST_LEN) : LEN_WIDTH'(rem_d);
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.rd_req_ready) begin
          cnt_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.rd_data_valid) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (last_beat) begin
            done_d = rem_q == REM_W'(len_q);
            state_d = done_d && !restart_d ? IDLE : WAIT_SPACE;
            addr_d = restart_d ? (rsel_d ? BASE_ADDR1 : BASE_ADDR0) : addr_q + ADDR_WIDTH'(32'(len_q) * BEAT_BYTES);
            rem_d = restart_d ? REM_W'(FRAME_BEATS) : rem_q - REM_W'(len_q);
            restart_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      restart_q <= 1'b0;
      rsel_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_data_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      restart_q <= restart_d;
      rsel_q <= rsel_d;
      wr_en_q <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      lerr_q <= lerr_d;
    end
  end
endmodule

// File: tb/tb_frame_fifo_fill_ctrl.sv
// tb_frame_fifo_fill_ctrl: frame-level model of the refill scheduler driving a randomized memory and FIFO
module tb_frame_fifo_fill_ctrl;
  localparam int FB = 200;
  localparam logic [27:0] B0 = 28'h0000000;
  localparam logic [27:0] B1 = 28'h0100000;
  typedef struct {
    logic sel;
    int ready_p;
    int af_p;
    int gap_p;
    logic [27:0] exp_first;
    logic [27:0] exp_last;
    int exp_reqs;
    int exp_last_len;
    int exp_writes;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic buf_sel = 1'b0;
  logic busy, frame_done, err_overflow, err_last;
  int total = 0;
  int bad = 0;
  int ready_p, af_p, gap_p, full_p, bad_last_at;
  bit stray, chk_b2b, fs_req, fs_sel;
  bit m_active, m_pend, m_pend_sel, m_ovf, m_lerr;
  logic [27:0] m_addr;
  int m_rem, b_left, b_idx, step_no, fin_step;
  bit exp_wr, exp_done, prev_valid, prev_af;
  logic [127:0] exp_wdata;
  logic [27:0] prev_addr;
  logic [7:0] prev_len;
  int n_req, n_wr, n_done, last_len;
  logic [27:0] first_addr, last_addr;
  logic [27:0] req_addr[$];
  vec_t vec[4];
  frame_fifo_fill_ctrl_if #(.ADDR_WIDTH(28), .LEN_WIDTH(8)) bus ();
  frame_fifo_fill_ctrl #(.FRAME_BEATS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .buf_sel(buf_sel), .bus(bus),
    .busy(busy), .frame_done(frame_done), .err_overflow(err_overflow), .err_last(err_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req_valid"}, bus.rd_req_valid, 0);
    chk({tag, "_req_addr"}, bus.rd_req_addr, 0);
    chk({tag, "_req_len"}, bus.rd_req_len, 0);
    chk({tag, "_wr_en"}, bus.fifo_wr_en, 0);
    chk({tag, "_wr_data"}, bus.fifo_wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_overflow"}, err_overflow, 0);
    chk({tag, "_err_last"}, err_last, 0);
  endtask
  task automatic clear_stats();
    n_req = 0;
    n_wr = 0;
    n_done = 0;
    last_len = 0;
    first_addr = '0;
    last_addr = '0;
    req_addr.delete();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    buf_sel = 1'b0;
    bus.rd_req_ready = 1'b0;
    bus.rd_data_valid = 1'b0;
    bus.rd_data = '0;
    bus.rd_data_last = 1'b0;
    bus.fifo_almost_full = 1'b0;
    bus.fifo_full = 1'b0;
    {m_active, m_pend, m_ovf, m_lerr, exp_wr, exp_done, prev_valid, prev_af, fs_req, stray} = '0;
    b_left = 0;
    b_idx = 0;
    fin_step = -1;
    bad_last_at = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  // one clock: check what the last edge produced, then drive memory/FIFO stimulus and advance the model
  task automatic cycle();
    logic v, lst, full, af, rdy;
    logic [127:0] d;
    int l;
    @(negedge clk);
    step_no++;
    chk("wr_en", bus.fifo_wr_en, exp_wr);
    if (exp_wr) chk("wr_data", bus.fifo_wr_data, exp_wdata);
    chk("frame_done", frame_done, exp_done);
    chk("busy", busy, m_active);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_last", err_last, m_lerr);
    if (bus.rd_req_valid) chk("one_outstanding", b_left == 0, 1);
    if (bus.rd_req_valid && !prev_valid) chk("af_gate", prev_af, 0);
    if (bus.rd_req_valid && prev_valid) begin
      chk("addr_stable", bus.rd_req_addr, prev_addr);
      chk("len_stable", bus.rd_req_len, prev_len);
    end
    if (bus.rd_req_valid && !prev_valid && fin_step >= 0) begin
      if (chk_b2b) chk("b2b_gap", step_no - fin_step, 2);
      fin_step = -1;
    end
    n_wr += int'(bus.fifo_wr_en);
    n_done += int'(frame_done);
    prev_valid = bus.rd_req_valid;
    prev_addr = bus.rd_req_addr;
    prev_len = bus.rd_req_len;
    exp_wr = 1'b0;
    exp_done = 1'b0;
    full = $urandom_range(99) < full_p;
    af = $urandom_range(99) < af_p;
    rdy = $urandom_range(99) < ready_p;
    frame_start = fs_req;
    buf_sel = fs_sel;
    if (fs_req) begin
      if (!m_active || !(bus.rd_req_valid || b_left > 0)) begin
        m_active = 1'b1;
        m_addr = fs_sel ? B1 : B0;
        m_rem = FB;
      end else begin
        m_pend = 1'b1;
        m_pend_sel = fs_sel;
      end
      fs_req = 1'b0;
    end
    v = 1'b0;
    lst = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    if (b_left > 0 && $urandom_range(99) >= gap_p) begin
      v = 1'b1;
      lst = (b_left == 1) ^ (b_idx == bad_last_at);
      if (b_idx == bad_last_at) m_lerr = 1'b1;
      exp_wr = 1'b1;
      exp_wdata = d;
      b_left--;
      b_idx++;
      if (b_left == 0) begin
        exp_done = m_rem == 0;
        if (m_pend) begin
          m_addr = m_pend_sel ? B1 : B0;
          m_rem = FB;
          m_pend = 1'b0;
        end else if (m_rem == 0) m_active = 1'b0;
        else fin_step = step_no;
      end
    end else if (stray) begin
      v = 1'b1;
      m_lerr = 1'b1;
    end
    if (v && full) m_ovf = 1'b1;
    bus.rd_data_valid = v;
    bus.rd_data_last = lst;
    bus.rd_data = d;
    bus.fifo_full = full;
    bus.fifo_almost_full = af;
    bus.rd_req_ready = rdy;
    prev_af = af;
    if (bus.rd_req_valid && rdy) begin
      l = m_rem < 64 ? m_rem : 64;
      chk("req_addr", bus.rd_req_addr, m_addr);
      chk("req_len", bus.rd_req_len, l);
      if (n_req == 0) first_addr = m_addr;
      last_addr = m_addr;
      last_len = l;
      req_addr.push_back(m_addr);
      n_req++;
      b_left = l;
      b_idx = 0;
      m_addr = m_addr + 28'(l * 16);
      m_rem -= l;
    end
  endtask
  task automatic run_to_idle(input int budget, input bit rnd_restart);
    int n = 0;
    int rs = 0;
    while ((fs_req || m_active || b_left > 0) && n < budget) begin
      if (rnd_restart && m_active && rs < 2 && $urandom_range(299) == 0) begin
        fs_req = 1'b1;
        fs_sel = 1'($urandom_range(1));
        rs++;
      end
      cycle();
      n++;
    end
    if (m_active || b_left > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: frame still busy after %0d cycles", budget);
    end
    cycle();
  endtask
  initial begin
    vec[0] = '{1'b0, 100, 0, 0, B0, B0 + 28'hC00, 4, 8, 200};
    vec[1] = '{1'b1, 100, 0, 0, B1, B1 + 28'hC00, 4, 8, 200};
    vec[2] = '{1'b0, 50, 30, 20, B0, B0 + 28'hC00, 4, 8, 200};
    vec[3] = '{1'b1, 30, 50, 40, B1, B1 + 28'hC00, 4, 8, 200};
    step_no = 0;
    full_p = 0;
    ready_p = 100;
    af_p = 0;
    gap_p = 0;
    chk_b2b = 1'b0;
    do_reset();
    chk_zero("reset");
    foreach (vec[i]) begin
      do_reset();
      clear_stats();
      ready_p = vec[i].ready_p;
      af_p = vec[i].af_p;
      gap_p = vec[i].gap_p;
      full_p = 0;
      chk_b2b = vec[i].af_p == 0;
      fs_req = 1'b1;
      fs_sel = vec[i].sel;
      run_to_idle(5000, 1'b0);
      chk("vec_n_req", n_req, vec[i].exp_reqs);
      chk("vec_first_addr", first_addr, vec[i].exp_first);
      chk("vec_last_addr", last_addr, vec[i].exp_last);
      chk("vec_last_len", last_len, vec[i].exp_last_len);
      chk("vec_writes", n_wr, vec[i].exp_writes);
      chk("vec_done", n_done, 1);
      chk("vec_busy_end", busy, 0);
    end
    chk_b2b = 1'b0;
    do_reset();
    clear_stats();
    ready_p = 0;
    af_p = 100;
    gap_p = 0;
    fs_req = 1'b1;
    fs_sel = 1'b0;
    cycle();
    cycle();
    chk("start_busy", busy, 1);
    for (int i = 0; i < 49; i++) begin
      cycle();
      chk("gate_hold", bus.rd_req_valid, 0);
    end
    af_p = 0;
    cycle();
    chk("gate_release", bus.rd_req_valid, 0);
    cycle();
    chk("gate_req", bus.rd_req_valid, 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stall_valid", bus.rd_req_valid, 1);
      chk("stall_no_write", bus.fifo_wr_en, 0);
    end
    ready_p = 100;
    run_to_idle(3000, 1'b0);
    chk("gate_done", n_done, 1);
    do_reset();
    clear_stats();
    fs_req = 1'b1;
    fs_sel = 1'b0;
    for (int i = 0; i < 100 && !(b_left > 0 && b_idx == 20); i++) cycle();
    fs_req = 1'b1;
    fs_sel = 1'b1;
    run_to_idle(3000, 1'b0);
    chk("restart_reqs", n_req, 5);
    chk("restart_addr", req_addr[1], B1);
    chk("restart_done", n_done, 1);
    do_reset();
    clear_stats();
    fs_req = 1'b1;
    fs_sel = 1'b0;
    for (int i = 0; i < 400 && !(b_left == 1 && m_rem == 0); i++) cycle();
    fs_req = 1'b1;
    fs_sel = 1'b1;
    run_to_idle(3000, 1'b0);
    chk("final_restart_reqs", n_req, 8);
    chk("final_restart_addr", req_addr[4], B1);
    chk("final_restart_done", n_done, 2);
    do_reset();
    stray = 1'b1;
    cycle();
    stray = 1'b0;
    cycle();
    chk("stray_err_last", err_last, 1);
    chk("stray_no_write", bus.fifo_wr_en, 0);
    do_reset();
    bad_last_at = 10;
    fs_req = 1'b1;
    run_to_idle(3000, 1'b0);
    chk("bad_last_err", err_last, 1);
    chk("bad_last_no_ovf", err_overflow, 0);
    bad_last_at = -1;
    full_p = 100;
    fs_req = 1'b1;
    run_to_idle(3000, 1'b0);
    full_p = 0;
    chk("ovf_err", err_overflow, 1);
    chk("last_sticky", err_last, 1);
    do_reset();
    cycle();
    chk("err_clear_ovf", err_overflow, 0);
    chk("err_clear_last", err_last, 0);
    do_reset();
    fs_req = 1'b1;
    fs_sel = 1'b0;
    for (int i = 0; i < 200 && !(b_left > 0 && b_idx >= 5); i++) cycle();
    #2 rst_n = 1'b0;
    #1 chk_zero("async");
    do_reset();
    clear_stats();
    cycle();
    chk("post_reset_idle", busy, 0);
    fs_req = 1'b1;
    fs_sel = 1'b1;
    run_to_idle(3000, 1'b0);
    chk("post_reset_first", first_addr, B1);
    chk("post_reset_done", n_done, 1);
    do_reset();
    for (int f = 0; f < 6; f++) begin
      ready_p = $urandom_range(100, 20);
      af_p = $urandom_range(60, 0);
      gap_p = $urandom_range(50, 0);
      full_p = $urandom_range(3, 0);
      fs_req = 1'b1;
      fs_sel = 1'($urandom_range(1));
      run_to_idle(8000, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_fifo_fill_ctrl.md
# frame_fifo_fill_ctrl

Write-side refill scheduler for the video frame FIFO (128-bit write, 1024-entry, almost_full at 960). On each frame start it walks the selected frame buffer in memory and issues fixed-length read bursts. It issues a burst only when the FIFO has room for a whole burst, and forwards returned beats into the FIFO write port. It sits in the memory/write clock domain, between the memory read port and the FIFO write side.

## Interface
Parameters:
- ADDR_WIDTH, 28, memory byte-address width
- BASE_ADDR0, 28'h0000000, frame buffer 0 byte base
- BASE_ADDR1, 28'h0100000, frame buffer 1 byte base
- FRAME_BEATS, 38400, 128-bit beats per frame (640x480x16 bpp)
- BURST_LEN, 64, maximum beats per burst; must be ≤ 1024−960
- BEAT_BYTES, 16, byte address increment per beat
- LEN_WIDTH, 8, burst length field width

Ports:
- clk, input, 1, memory/FIFO write clock
- rst_n, input, 1, asynchronous active-low reset
- frame_start, input, 1, single-cycle pulse, already synchronous to clk
- buf_sel, input, 1, frame buffer select, sampled on frame_start
- rd_req_valid, output, 1, burst request valid
- rd_req_ready, input, 1, burst request accepted
- rd_req_addr, output, ADDR_WIDTH, burst start byte address
- rd_req_len, output, LEN_WIDTH, beats in burst (1..BURST_LEN)
- rd_data_valid, input, 1, returned beat valid; no backpressure
- rd_data, input, 128, returned beat
- rd_data_last, input, 1, last beat of burst
- fifo_wr_en, output, 1, FIFO write enable
- fifo_wr_data, output, 128, FIFO write data
- fifo_almost_full, input, 1, FIFO almost_full
- fifo_full, input, 1, FIFO wr_full
- busy, output, 1, frame transfer in progress
- frame_done, output, 1, one-cycle pulse when all FRAME_BEATS are written
- err_overflow, output, 1, sticky: beat arrived while fifo_full
- err_last, output, 1, sticky: rd_data_last disagreed with the beat count

## Operation
- FSM states: IDLE, WAIT_SPACE, REQ, DATA.
- IDLE:
  - On frame_start: addr ← buf_sel ? BASE_ADDR1 : BASE_ADDR0.
  - remaining ← FRAME_BEATS.
  - Go to WAIT_SPACE.
- WAIT_SPACE:
  - If !fifo_almost_full: len ← min(BURST_LEN, remaining), go to REQ.
- REQ:
  - rd_req_valid=1; rd_req_addr and rd_req_len stay stable until rd_req_ready.
  - On handshake: beat_cnt ← 0, go to DATA.
- DATA:
  - Each rd_data_valid beat is forwarded to the FIFO and increments beat_cnt.
  - On the beat where beat_cnt == len−1:
    - addr ← addr + len·BEAT_BYTES, modulo 2^ADDR_WIDTH.
    - remaining ← remaining − len.
    - If remaining reaches 0: pulse frame_done, go to IDLE.
    - Otherwise go to WAIT_SPACE.
- Only one burst is outstanding at a time. The 64-entry almost_full headroom guarantees space for the whole burst.
- frame_start while busy:
  - Latched as restart_pending; never aborts an accepted request or a burst in flight.
  - At the next WAIT_SPACE entry (or immediately if already in WAIT_SPACE), re-initialise addr and remaining with the buf_sel value latched with the pulse. No frame_done is pulsed for the abandoned frame.
  - frame_start in the same cycle as the final beat: frame_done pulses, and the FSM goes to WAIT_SPACE for the new frame instead of IDLE.
- err_last:
  - Set when rd_data_last=1 on a beat other than len−1, or rd_data_last=0 on beat len−1.
  - Counting by beat_cnt still governs progress.
- err_overflow:
  - Set when rd_data_valid=1 while fifo_full=1.
  - The beat is still presented to the FIFO, which drops it.
- rd_data_valid outside DATA is ignored and sets err_last.
- busy=1 in every state except IDLE.

## Timing
- Reset values:
  - rd_req_valid=0, rd_req_addr=0, rd_req_len=0.
  - fifo_wr_en=0, fifo_wr_data=0.
  - busy=0, frame_done=0, err_overflow=0, err_last=0.
  - FSM=IDLE, restart_pending=0.
- rst_n mid-operation: everything returns to reset values immediately. Any burst still in flight must be flushed by the memory side.
- frame_start at cycle N: WAIT_SPACE and busy=1 at N+1.
- fifo_almost_full=0 sampled at cycle M in WAIT_SPACE: rd_req_valid=1 at M+1.
- Request handshake at cycle K: DATA from K+1. A beat accepted in K+1 is valid.
- Forwarding is registered:
  - rd_data_valid at cycle T gives fifo_wr_en=1 and fifo_wr_data=rd_data at T+1.
  - Throughput is one beat per cycle.
- frame_done is asserted at T+1 for final beat T, aligned with that beat's fifo_wr_en.
- Back-to-back bursts: final beat at T → WAIT_SPACE at T+1 → earliest next rd_req_valid at T+2.

## Test plan
- Full frame, FRAME_BEATS=200, BURST_LEN=64, buf_sel=0, ready always 1, almost_full=0:
  - 4 requests with len 64/64/64/8 at addrs 0x0, 0x400, 0x800, 0xC00.
  - 200 fifo_wr_en pulses, one frame_done, busy then drops to 0.
- Space gating: hold fifo_almost_full=1 for 50 cycles after frame_start.
  - rd_req_valid stays 0 for those cycles.
  - Request issued 1 cycle after release.
- Request stall: rd_req_ready low for 10 cycles.
  - rd_req_valid, addr and len stay stable.
  - No beats forwarded before the handshake.
- Restart: frame_start with buf_sel=1 mid-burst.
  - The burst completes, then the next request goes to BASE_ADDR1 with full remaining.
  - No frame_done for the first frame.
- Errors:
  - rd_data_last on beat 10 of a len-64 burst → err_last=1.
  - A beat with fifo_full=1 → err_overflow=1.
  - Both stay set until rst_n.
- Async reset asserted during DATA: all outputs read 0 in the same cycle, and the FSM is in IDLE after release.
